// File: rtl/instruction_prefetch_buffer_pkg.sv
// Shared prefetch definitions: FSM encoding,
// reset fetch address, NOP word, queue entry.
package instruction_prefetch_buffer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } pf_entry_t;

endpackage

// File: rtl/instruction_prefetch_buffer_fifo.sv
// prefetch_fifo: DEPTH x 64-bit queue, push/pop/flush.
// Ports: push/push_data in, pop in, count/head out.
module prefetch_fifo
  import instruction_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  pf_entry_t                push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output pf_entry_t                head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pf_entry_t       mem_q [DEPTH];
  pf_entry_t       last_q, last_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign push_ok = push && !flush
                && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && !flush
                && (count_q != '0);

  // When empty, show whatever was shown last
  assign head   = (count_q != '0) ? mem_q[rd_ptr_q]
                                  : last_q;
  assign last_d = head;
  assign count  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok)
              - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '{instr: NOP_INSTR, pc_plus4: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited fetch,
// in-order queue, redirect with stale-response drop.
module instruction_prefetch_buffer
  import instruction_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] count, credit, stale;
  pf_entry_t     push_data, head;
  logic          run, accept, resp, push, pop;

  assign run       = state_q == ST_RUN;
  assign credit    = count + outst_q;
  assign imem_req  = run && (credit < CW'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;
  assign resp      = imem_valid && (state_q != ST_IDLE);
  assign push      = imem_valid && run && !redirect;

  // Responses are in order: the oldest outstanding
  // fetch sits outst_q words behind fetch_pc_q.
  assign push_data = {imem_rdata,
                      fetch_pc_q
                      - 32'({outst_q, 2'b00})
                      + 32'd4};

  assign out_valid    = count != '0;
  assign pop          = out_valid && !hold && !redirect;
  assign out_instr    = head.instr;
  assign out_pc_plus4 = head.pc_plus4;

  // Everything in flight after a redirect edge is stale,
  // including a request accepted in the redirect cycle.
  assign stale = disc_q + outst_q + CW'(accept)
               - CW'(resp);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      outst_d    = '0;
      disc_d     = stale;
      state_d    = (stale != '0) ? ST_DISCARD : ST_RUN;
    end else begin
      unique case (1'b1)
        state_q == ST_IDLE: begin
          state_d = ST_RUN;
        end
        state_q == ST_RUN: begin
          if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
          outst_d = outst_q + CW'(accept)
                  - CW'(imem_valid);
        end
        state_q == ST_DISCARD: begin
          if (imem_valid) begin
            disc_d = disc_q - CW'(1);
            if (disc_q == CW'(1)) state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .flush    (redirect),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: memory
// model, epoch-tagged scoreboard, scenario tasks.
module tb_instruction_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;

  always #5 clk = ~clk;

  instruction_prefetch_buffer #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold        (hold),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc_plus4(out_pc_plus4)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
  } req_t;

  int          total = 0;
  int          bad   = 0;
  req_t        inflight[$];
  logic [63:0] exp_q[$];
  logic [31:0] popped[$];
  logic [31:0] acc_log[$];
  int          epoch    = 0;
  logic [31:0] exp_addr = 32'h0;
  bit          resp_en  = 1'b0;
  int          acc_cnt  = 0;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic step();
    req_t        r;
    logic [63:0] e;
    bit          rs;
    rs         = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    if (resp_en && inflight.size() > 0) begin
      r          = inflight.pop_front();
      imem_valid = 1'b1;
      imem_rdata = mem_word(r.addr);
      rs         = 1'b1;
    end
    if (!reset) begin
      exp_q.delete();
      epoch++;
      exp_addr = 32'h0;
    end else begin
      total++;
      if (out_valid !== (exp_q.size() > 0)) begin
        bad++;
        $display("FAIL out_valid_track got=%b want=%b",
                 out_valid, exp_q.size() > 0);
      end
      if (out_valid && !hold && !redirect
          && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({out_instr, out_pc_plus4} !== e) begin
          bad++;
          $display("FAIL pop_data got=%h want=%h",
                   {out_instr, out_pc_plus4}, e);
        end
        popped.push_back(out_pc_plus4);
      end
      if (imem_req && imem_ready) begin
        total++;
        if (imem_addr !== exp_addr) begin
          bad++;
          $display("FAIL fetch_addr got=%h want=%h",
                   imem_addr, exp_addr);
        end
        inflight.push_back('{imem_addr, epoch});
        acc_log.push_back(imem_addr);
        acc_cnt++;
        exp_addr = imem_addr + 32'd4;
      end
      if (rs && r.ep == epoch && !redirect)
        exp_q.push_back({mem_word(r.addr),
                         r.addr + 32'd4});
      if (redirect) begin
        exp_q.delete();
        epoch++;
        exp_addr = redirect_pc & ~32'h3;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    hold       = 1'b0;
    imem_ready = 1'b0;
    resp_en    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (inflight.size() == 0 && !out_valid) break;
      step();
    end
    total++;
    if (inflight.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d/%b want=0/0",
               inflight.size(), out_valid);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    total++;
    if ({imem_req, out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL %s_flags got=%b want=00",
               tag, {imem_req, out_valid});
    end
    total++;
    if (out_instr !== 32'h0
        || out_pc_plus4 !== 32'h0) begin
      bad++;
      $display("FAIL %s_out got=%h/%h want=0/0",
               tag, out_instr, out_pc_plus4);
    end
    total++;
    if (imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL %s_addr got=%h want=0", tag, imem_addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    check_reset_outs("reset");
    reset      = 1'b1;
    imem_ready = 1'b1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_req got=%b want=0", imem_req);
    end
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL first_req got=%b/%h want=1/0",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    imem_ready = 1'b1;
    resp_en    = 1'b1;
    hold       = 1'b0;
    popped.delete();
    acc_log.delete();
    repeat (12) step();
    total++;
    if (acc_log.size() < 4 || popped.size() < 4) begin
      bad++;
      $display("FAIL stream_len got=%0d/%0d want=4/4",
               acc_log.size(), popped.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        a = 32'(i * 4);
        total++;
        if (acc_log[i] !== a) begin
          bad++;
          $display("FAIL stream_addr got=%h want=%h",
                   acc_log[i], a);
        end
        total++;
        if (popped[i] !== a + 32'd4) begin
          bad++;
          $display("FAIL stream_pc4 got=%h want=%h",
                   popped[i], a + 32'd4);
        end
      end
    end
  endtask

  task automatic test_hold();
    int          n0;
    logic [31:0] base;
    n0   = popped.size();
    base = popped[n0-1];
    hold = 1'b1;
    repeat (10) step();
    total++;
    if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_full got=%b/%b want=0/1",
               imem_req, out_valid);
    end
    total++;
    if (popped.size() != n0 || inflight.size() != 0) begin
      bad++;
      $display("FAIL hold_state got=%0d/%0d want=%0d/0",
               popped.size(), inflight.size(), n0);
    end
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_release got=%b want=1",
                 out_valid);
      end
      step();
    end
    total++;
    if (popped.size() != n0 + 4) begin
      bad++;
      $display("FAIL hold_pops got=%0d want=%0d",
               popped.size(), n0 + 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (popped[n0+i] !== base + 32'(4 * (i + 1))) begin
          bad++;
          $display("FAIL hold_order got=%h want=%h",
                   popped[n0+i], base + 32'(4 * (i + 1)));
        end
      end
    end
  endtask

  task automatic test_redirect();
    drain();
    resp_en    = 1'b0;
    imem_ready = 1'b1;
    acc_cnt    = 0;
    for (int i = 0; i < 20; i++) begin
      if (acc_cnt >= 3) break;
      step();
    end
    imem_ready = 1'b0;
    total++;
    if (acc_cnt != 3) begin
      bad++;
      $display("FAIL redir_setup got=%0d want=3", acc_cnt);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL redir_discard got=%b/%h want=0/100",
               imem_req, imem_addr);
    end
    popped.delete();
    acc_log.delete();
    resp_en    = 1'b1;
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b0) begin
        bad++;
        $display("FAIL redir_drop_req got=%b want=0",
                 imem_req);
      end
      step();
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL redir_resume got=%b/%h want=1/100",
               imem_req, imem_addr);
    end
    repeat (8) step();
    total++;
    if (popped.size() == 0 || popped[0] !== 32'h104) begin
      bad++;
      $display("FAIL redir_first got=%h want=104",
               popped.size() ? popped[0] : 32'hX);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wa [3];
    logic [31:0] wp [3];
    wa[0] = 32'hFFFF_FFF8;
    wa[1] = 32'hFFFF_FFFC;
    wa[2] = 32'h0000_0000;
    wp[0] = 32'hFFFF_FFFC;
    wp[1] = 32'h0000_0000;
    wp[2] = 32'h0000_0004;
    drain();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    acc_log.delete();
    popped.delete();
    imem_ready = 1'b1;
    resp_en    = 1'b1;
    repeat (8) step();
    total++;
    if (acc_log.size() < 3 || popped.size() < 3) begin
      bad++;
      $display("FAIL wrap_len got=%0d/%0d want=3/3",
               acc_log.size(), popped.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (acc_log[i] !== wa[i]) begin
          bad++;
          $display("FAIL wrap_addr got=%h want=%h",
                   acc_log[i], wa[i]);
        end
        total++;
        if (popped[i] !== wp[i]) begin
          bad++;
          $display("FAIL wrap_pc4 got=%h want=%h",
                   popped[i], wp[i]);
        end
      end
    end
  endtask

  task automatic test_redirect_hold();
    imem_ready = 1'b1;
    resp_en    = 1'b1;
    hold       = 1'b1;
    repeat (2) step();
    total++;
    if (out_valid !== 1'b1 || inflight.size() == 0) begin
      bad++;
      $display("FAIL rh_setup got=%b/%0d want=1/>0",
               out_valid, inflight.size());
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    step();
    redirect = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rh_empty got=%b want=0", out_valid);
    end
    hold = 1'b0;
    popped.delete();
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rh_dropped got=%b want=0", out_valid);
    end
    repeat (8) step();
    total++;
    if (popped.size() == 0 || popped[0] !== 32'h2004) begin
      bad++;
      $display("FAIL rh_first got=%h want=2004",
               popped.size() ? popped[0] : 32'hX);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    resp_en    = 1'b0;
    imem_ready = 1'b1;
    acc_cnt    = 0;
    for (int i = 0; i < 20; i++) begin
      if (acc_cnt >= 2) break;
      step();
    end
    imem_ready = 1'b0;
    total++;
    if (acc_cnt != 2) begin
      bad++;
      $display("FAIL rm_setup got=%0d want=2", acc_cnt);
    end
    reset = 1'b0;
    #1;
    check_reset_outs("rm");
    resp_en = 1'b1;
    repeat (3) step();
    reset      = 1'b1;
    imem_ready = 1'b1;
    popped.delete();
    repeat (12) step();
    total++;
    if (popped.size() == 0 || popped[0] !== 32'h4) begin
      bad++;
      $display("FAIL rm_first got=%h want=4",
               popped.size() ? popped[0] : 32'hX);
    end
  endtask

  initial begin
    reset       = 1'b0;
    imem_ready  = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    hold        = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_hold();
    test_redirect();
    test_wrap();
    test_redirect_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_prefetch_buffer.md
INSTRUCTION_PREFETCH_BUFFER -- requirements
Module: instruction_prefetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: queue entries and the maximum number of outstanding fetches (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 The block SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_req  out  1  fetch request valid.
REQ-006 The block SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-007 The block SHALL have port imem_ready  in  1  memory accepts the request this cycle.
REQ-008 The block SHALL have port imem_valid  in  1  in-order response valid.
REQ-009 The block SHALL have port imem_rdata  in  32  response instruction word.
REQ-010 The block SHALL have port redirect  in  1  taken branch from the decode stage.
REQ-011 The block SHALL have port redirect_pc  in  32  branch target.
REQ-012 The block SHALL have port hold  in  1  decode-stage stall (holdIF_ID).
REQ-013 The block SHALL have port out_valid  out  1  head entry valid toward the IF/ID register.
REQ-014 The block SHALL have port out_instr  out  32  head instruction.
REQ-015 The block SHALL have port out_pc_plus4  out  32  head fetch address + 4.

Function
REQ-016 States SHALL be IDLE (first cycle after reset, no request), RUN (normal fetch) and DISCARD (drop stale responses); IDLE->RUN is unconditional.
REQ-017 Handshake: a fetch SHALL be accepted when imem_req && imem_ready; imem_req and imem_addr SHALL stay stable until acceptance.
REQ-018 In RUN, imem_req SHALL be high iff count + outstanding < DEPTH (credit rule), so the queue never overflows.
REQ-019 On acceptance, fetch_pc SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-020 An imem_valid response in RUN SHALL be written at the tail together with its fetch address + 4, with outstanding decremented.
REQ-021 Write latency: an entry written in cycle N SHALL raise out_valid in cycle N+1; there is no combinational bypass.
REQ-022 Pop SHALL occur when out_valid && !hold; simultaneous push and pop SHALL leave count unchanged.
REQ-023 When empty, out_valid SHALL be 0, and out_instr / out_pc_plus4 SHALL hold their last values.
REQ-024 On redirect, the block SHALL take the following actions on the next edge: queue emptied, fetch_pc <= {redirect_pc[31:2],2'b00}, discard counter <= outstanding (minus one if a response arrives that cycle), next state DISCARD if the result is nonzero, else RUN.
REQ-025 Redirect SHALL win over hold, pop, push and a same-cycle acceptance; a request accepted in the redirect cycle SHALL count as stale.
REQ-026 In DISCARD, imem_req SHALL be 0; each imem_valid SHALL decrement the discard counter without writing; reaching 0 SHALL return to RUN.
REQ-027 A redirect during DISCARD SHALL reload fetch_pc and keep discarding the remaining stale responses.
REQ-028 A hold lasting any length SHALL lose no entries; fetching SHALL continue until credits are exhausted.

Reset
REQ-029 While reset is low, the following SHALL be forced: state=IDLE, fetch_pc=RESET_PC, count/outstanding/discard=0, imem_req=0, out_valid=0, out_instr=0, out_pc_plus4=0.
REQ-030 Reset asserted mid-operation SHALL abandon outstanding fetches, and responses arriving during reset SHALL be ignored.
REQ-031 The first request SHALL issue in the second rising edge after reset deasserts, with imem_addr=RESET_PC.

Structure
REQ-032 The state encoding, RESET_PC default and NOP word (32'h0) SHALL belong in the shared processor package.
REQ-033 Queue storage SHALL be one sub-module, prefetch_fifo (DEPTH entries × 64 bits, push/pop/count), instantiated once.
REQ-034 The FSM, credit counters and fetch_pc SHALL reside in the top level.

Verification
REQ-035 The bench SHALL cover reset release with imem_ready=1 and a 1-cycle response -> requests at 0x0,0x4,0x8,0xC; out_pc_plus4 0x4,0x8,... in order.
REQ-036 The bench SHALL cover hold=1 for 10 cycles -> count reaches 4, imem_req=0, and after release 4 consecutive pops with no loss or duplication.
REQ-037 The bench SHALL cover redirect to 0x0000_0103 with 3 fetches outstanding -> next imem_addr=0x100, 3 responses dropped, and first out_pc_plus4=0x104.
REQ-038 The bench SHALL cover fetch_pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-039 The bench SHALL cover redirect and hold high in the same cycle, with one response arriving -> queue empty, the response discarded, and out_valid=0 the next cycle.
REQ-040 The bench SHALL cover reset asserted with 2 fetches outstanding -> all outputs at reset values; stale responses after release never appear on out_instr.
